thread_scheduler: RTL
=====================

Name: thread_scheduler

Overview:
Barrel-thread issue controller sitting in front of the fetch stage of the multithreaded 5-stage RV32 core. It owns the per-thread PC table and the active/in-flight state. Each cycle it selects the next eligible hardware thread round-robin and issues its tid and PC to fetch. It takes branch/jump resolution and halt events back from execute, and start/stop commands from the host/debug side.

Parameters:
ADDRESS_WIDTH, 32, PC width.
NUM_THREADS, 8, hardware thread count; power of two, at least 2.
RESET_PC, 0, PC loaded into every table entry at reset.
START_MASK, 1, threads active out of reset (bit t = thread t).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
resolve_valid  in  1  execute resolved the in-flight instruction of resolve_tid
resolve_tid  in  BITS_THREADS  thread being resolved (BITS_THREADS = clog2(NUM_THREADS))
redirect  in  1  qualifies resolve_valid; taken branch/jump
redirect_pc  in  ADDRESS_WIDTH  target PC when redirect=1
halt_valid  in  1  thread halt request from the pipeline (ecall/ebreak)
halt_tid  in  BITS_THREADS  thread to halt
cmd_valid  in  1  host command strobe
cmd_op  in  2  00 nop, 01 start, 10 stop, 11 nop
cmd_tid  in  BITS_THREADS  command target thread
cmd_pc  in  ADDRESS_WIDTH  start PC for cmd_op=01
issue_valid  out  1  registered; issue_tid/issue_pc valid this cycle
issue_tid  out  BITS_THREADS  registered thread id to fetch
issue_pc  out  ADDRESS_WIDTH  registered PC to fetch
cmd_err  out  1  registered one-cycle pulse; command rejected
active_mask  out  NUM_THREADS  registered active flags
all_idle  out  1  no thread active and none in flight

Behaviour:
- Reset (rst=0 at posedge): pc_table[*]=RESET_PC; active=START_MASK; inflight=0; last_tid=NUM_THREADS-1 so thread 0 is searched first; issue_valid=0; issue_tid=0; issue_pc=0; cmd_err=0. Reset overrides every other input in that cycle and aborts any in-flight bookkeeping.
- Eligibility, from registered state only: elig[t] = active[t] & ~inflight[t].
- Selection: rotate-priority search starting at (last_tid+1) mod NUM_THREADS and wrapping. The first eligible t wins.
- On a winner, at the next edge:
  - issue_valid=1, issue_tid=t, issue_pc=pc_table[t].
  - inflight[t]=1; pc_table[t]=pc_table[t]+4, modulo 2^ADDRESS_WIDTH.
  - last_tid=t.
- With no winner: issue_valid=0, issue_tid/issue_pc hold, last_tid holds.
- Latency: one cycle from state to issue. Each thread has at most one instruction in flight.
- A resolved thread becomes eligible no earlier than the cycle after resolve. There is no same-cycle bypass.
- Resolve (resolve_valid=1) clears inflight[resolve_tid]. If redirect=1 it also sets pc_table[resolve_tid]=redirect_pc; otherwise the speculative +4 value stands.
- Resolve of a thread with inflight=0 is ignored. The checker asserts it never occurs.
- Start: accepted only when ~active[cmd_tid] & ~inflight[cmd_tid]. Sets active and pc_table[cmd_tid]=cmd_pc. Otherwise rejected: no state change, cmd_err=1 next cycle.
- Stop: clears active[cmd_tid] and is always accepted. An in-flight instruction still resolves normally, and its redirect still updates pc_table.
- Halt: clears active[halt_tid]. Same semantics as stop, but never raises cmd_err.
- Same-cycle priority on active[t]: halt/stop clear beats start set.
  - A start that collides with a halt of the same tid is reported as rejected (cmd_err=1).
  - A start to a tid being resolved in the same cycle is rejected, because inflight is still 1.
- No pc_table write collision is possible, by construction:
  - issue increment needs inflight=0;
  - resolve needs inflight=1;
  - start needs inflight=0 and active=0.
- all_idle = ~|active & ~|inflight, computed from registered state.
- An issue fires in the same cycle as a stop/halt of that thread. This is legal: the instruction completes.

Decomposition:
- Shared package sched_pkg: cmd op constants (CMD_NOP, CMD_START, CMD_STOP), the BITS_THREADS derivation, and the PC increment constant 4.
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs are the request vector and last_tid; outputs are grant_valid and grant_tid. It is reused by future shared-resource arbiters (e.g. dmem port).

Test Plan:
- Reset, START_MASK=1, RESET_PC=0 → cycle 1: issue_valid=1, tid=0, pc=0x0. Next cycles issue_valid=0 until resolve_tid=0. One cycle after resolve: tid=0, pc=0x4.
- Start tids 1 and 2 at 0x100/0x200, then resolve every issue 2 cycles later → issue order 0,1,2,0,1,2… with per-thread PCs advancing by 4.
- Resolve tid=1 with redirect=1, redirect_pc=0x400 → next issue of tid 1 has pc=0x400, then 0x404.
- Start tid 3 while active → cmd_err pulse, active_mask unchanged. Stop tid 3, then start it before its resolve → cmd_err. Start again after resolve → accepted.
- Same cycle: halt_tid=2 and cmd start tid=2 → active[2]=0, cmd_err=1. An outstanding tid 2 instruction still resolves; all_idle=1 once all threads are stopped and resolved.
- Assert rst=0 mid-run with 3 threads in flight → next cycle issue_valid=0, inflight=0, active_mask=START_MASK, all pc_table entries =RESET_PC.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the barrel-thread scheduler and its arbiters.
package sched_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_NOP_3 = 2'b11
  } cmd_op_e;

  localparam int unsigned PC_INC = 4;

  // Thread-id width; a single thread still needs one bit to name it.
  function automatic int bits_threads(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: search starts just after last_i and wraps.
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         grant_valid_o,
  output logic [W-1:0] grant_tid_o
);

  logic [W-1:0] idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_tid_o   = '0;
    idx           = '0;
    // N is a power of two, so W-bit wraparound gives the modulo for free.
    for (int i = 1; i <= N; i++) begin
      idx = last_i + W'(i);
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_tid_o   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-thread issue controller: owns the PC table and active/in-flight state, issues one thread per cycle.
module thread_scheduler
  import sched_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         NUM_THREADS   = 8,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter logic [NUM_THREADS-1:0]     START_MASK    = 1,
  localparam int                        BITS_THREADS  = bits_threads(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     resolve_valid,
  input  logic [BITS_THREADS-1:0]  resolve_tid,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_valid,
  input  logic [BITS_THREADS-1:0]  halt_tid,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [BITS_THREADS-1:0]  cmd_tid,
  input  logic [ADDRESS_WIDTH-1:0] cmd_pc,
  output logic                     issue_valid,
  output logic [BITS_THREADS-1:0]  issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
  output logic                     cmd_err,
  output logic [NUM_THREADS-1:0]   active_mask,
  output logic                     all_idle
);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]   active_q, active_d;
  logic [NUM_THREADS-1:0]   inflight_q, inflight_d;
  logic [BITS_THREADS-1:0]  last_q, last_d;
  logic                     issue_valid_q, issue_valid_d;
  logic [BITS_THREADS-1:0]  issue_tid_q, issue_tid_d;
  logic [ADDRESS_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic                     cmd_err_q, cmd_err_d;

  logic                     grant_valid;
  logic [BITS_THREADS-1:0]  grant_tid;
  logic                     start_ok;

  rr_pick #(
    .N (NUM_THREADS),
    .W (BITS_THREADS)
  ) u_pick (
    .req_i         (active_q & ~inflight_q),
    .last_i        (last_q),
    .grant_valid_o (grant_valid),
    .grant_tid_o   (grant_tid)
  );

  // A start colliding with a same-tid halt loses, so it is reported as rejected.
  assign start_ok = !active_q[cmd_tid] && !inflight_q[cmd_tid] &&
                    !(halt_valid && (halt_tid == cmd_tid));

  always_comb begin
    pc_d          = pc_q;
    active_d      = active_q;
    inflight_d    = inflight_q;
    last_d        = last_q;
    issue_valid_d = 1'b0;
    issue_tid_d   = issue_tid_q;
    issue_pc_d    = issue_pc_q;
    cmd_err_d     = 1'b0;

    if (grant_valid) begin
      issue_valid_d         = 1'b1;
      issue_tid_d           = grant_tid;
      issue_pc_d            = pc_q[grant_tid];
      pc_d[grant_tid]       = pc_q[grant_tid] + ADDRESS_WIDTH'(PC_INC);
      inflight_d[grant_tid] = 1'b1;
      last_d                = grant_tid;
    end

    // Issue, resolve and start touch disjoint entries, so write order does not matter.
    if (resolve_valid && inflight_q[resolve_tid]) begin
      inflight_d[resolve_tid] = 1'b0;
      if (redirect) pc_d[resolve_tid] = redirect_pc;
    end

    if (cmd_valid) begin
      case (cmd_op)
        CMD_START: begin
          if (start_ok) begin
            active_d[cmd_tid] = 1'b1;
            pc_d[cmd_tid]     = cmd_pc;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_STOP: active_d[cmd_tid] = 1'b0;
        default:  ;
      endcase
    end

    if (halt_valid) active_d[halt_tid] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
      active_q      <= START_MASK;
      inflight_q    <= '0;
      last_q        <= BITS_THREADS'(NUM_THREADS - 1);
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      issue_pc_q    <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      active_q      <= active_d;
      inflight_q    <= inflight_d;
      last_q        <= last_d;
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      issue_pc_q    <= issue_pc_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_tid   = issue_tid_q;
  assign issue_pc    = issue_pc_q;
  assign cmd_err     = cmd_err_q;
  assign active_mask = active_q;
  assign all_idle    = ~|active_q & ~|inflight_q;

  resolve_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
    resolve_valid |-> inflight_q[resolve_tid]);

endmodule
